// File: rtl/sys_reset_ctrl.sv
// System reset controller: synchronises and stretches power-on reset, merges maskable
// CPU reset requests with a LOCKUP-timeout auto-reset, and keeps sticky debug counters.
module sys_reset_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_REQ        = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int LOCKUP_TIMEOUT = 32,
    parameter int CNT_W          = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_REQ-1:0] SYSRESETREQ_in,
    input  logic [NUM_REQ-1:0] rst_req_mask,
    input  logic               LOCKUP_in,
    input  logic               lockup_rst_en,
    input  logic               TXEV_in,
    input  logic               rst_cause_clr,
    output logic               sys_rst_n_out,
    output logic [NUM_REQ+1:0] rst_cause_out,
    output logic [7:0]         reset_count_out,
    output logic [CNT_W-1:0]   txev_count_out,
    output logic [1:0]         state_out
);

    localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int LKW = (LOCKUP_TIMEOUT > 1) ? $clog2(LOCKUP_TIMEOUT) : 1;
    localparam int CW  = NUM_REQ + 2;
    localparam logic [SCW-1:0] STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);
    localparam logic [LKW-1:0] LOCKUP_LAST  = LKW'((LOCKUP_TIMEOUT > 0) ? LOCKUP_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_RST      = 2'd0,
        ST_STRETCH  = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SCW-1:0]       cnt_q, cnt_d;
    logic [LKW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                 sys_rst_n_q, sys_rst_n_d;
    logic [CW-1:0]        cause_q, cause_d;
    logic [7:0]           rcnt_q, rcnt_d;
    logic [CNT_W-1:0]     txev_q, txev_d;

    logic [NUM_REQ-1:0]   act_vec;
    logic                 act_req;
    logic                 in_run;
    logic                 lk_qual;
    logic                 lk_fire;
    logic                 trig;
    logic                 enter_stretch;

    always_comb begin
        act_vec = SYSRESETREQ_in & ~rst_req_mask;
        act_req = |act_vec;
        in_run  = (state_q == ST_RUN);
        lk_qual = in_run && (LOCKUP_TIMEOUT != 0) && LOCKUP_in && lockup_rst_en;
        lk_fire = lk_qual && (lock_cnt_q == LOCKUP_LAST);
        trig    = in_run && (act_req || lk_fire);

        state_d     = state_q;
        cnt_d       = cnt_q;
        sys_rst_n_d = sys_rst_n_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};

        case (state_q)
            ST_RST: begin
                sys_rst_n_d = 1'b0;
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_STRETCH;
                    cnt_d   = STRETCH_LAST;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == '0) begin
                    if (act_req) begin
                        state_d = ST_WAIT_REL;
                    end else begin
                        state_d     = ST_RUN;
                        sys_rst_n_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!act_req) begin
                    state_d     = ST_RUN;
                    sys_rst_n_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (trig) begin
                    state_d     = ST_STRETCH;
                    cnt_d       = STRETCH_LAST;
                    sys_rst_n_d = 1'b0;
                end
            end
        endcase

        enter_stretch = (state_d == ST_STRETCH) && (state_q != ST_STRETCH);

        // The lockup run length only accumulates while running; any exit zeroes it.
        lock_cnt_d = (lk_qual && !trig) ? lock_cnt_q + LKW'(1) : '0;

        // New cause bits are ORed after the clear so a coincident trigger survives it.
        cause_d = (rst_cause_clr ? '0 : cause_q) | (trig ? {lk_fire, act_vec, 1'b0} : '0);

        rcnt_d = (trig && rcnt_q != 8'hFF) ? rcnt_q + 8'd1 : rcnt_q;

        if (enter_stretch)
            txev_d = '0;
        else if (in_run && TXEV_in && txev_q != '1)
            txev_d = txev_q + CNT_W'(1);
        else
            txev_d = txev_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_RST;
            sync_q      <= '0;
            cnt_q       <= '0;
            lock_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            cause_q     <= CW'(1);
            rcnt_q      <= '0;
            txev_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            cause_q     <= cause_d;
            rcnt_q      <= rcnt_d;
            txev_q      <= txev_d;
        end
    end

    assign sys_rst_n_out   = sys_rst_n_q;
    assign rst_cause_out   = cause_q;
    assign reset_count_out = rcnt_q;
    assign txev_count_out  = txev_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Scoreboard bench for sys_reset_ctrl: directed scenarios then biased random traffic,
// each edge's expected outputs queued by the driver and popped by an independent monitor.
module tb_sys_reset_ctrl;

    localparam int SS    = 2;
    localparam int NR    = 2;
    localparam int SC    = 16;
    localparam int LT    = 32;
    localparam int CW    = 3;
    localparam int TXMAX = (1 << CW) - 1;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic [NR-1:0] SYSRESETREQ_in = '0;
    logic [NR-1:0] rst_req_mask = '0;
    logic          LOCKUP_in = 1'b0;
    logic          lockup_rst_en = 1'b0;
    logic          TXEV_in = 1'b0;
    logic          rst_cause_clr = 1'b0;
    logic          sys_rst_n_out;
    logic [NR+1:0] rst_cause_out;
    logic [7:0]    reset_count_out;
    logic [CW-1:0] txev_count_out;
    logic [1:0]    state_out;

    always #5 HCLK = ~HCLK;

    sys_reset_ctrl #(
        .SYNC_STAGES(SS), .NUM_REQ(NR), .STRETCH_CYCLES(SC),
        .LOCKUP_TIMEOUT(LT), .CNT_W(CW)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .SYSRESETREQ_in(SYSRESETREQ_in), .rst_req_mask(rst_req_mask),
        .LOCKUP_in(LOCKUP_in), .lockup_rst_en(lockup_rst_en),
        .TXEV_in(TXEV_in), .rst_cause_clr(rst_cause_clr),
        .sys_rst_n_out(sys_rst_n_out), .rst_cause_out(rst_cause_out),
        .reset_count_out(reset_count_out), .txev_count_out(txev_count_out),
        .state_out(state_out)
    );

    typedef struct {
        logic          rstn;
        logic [1:0]    st;
        logic [NR+1:0] cause;
        logic [7:0]    rc;
        logic [CW-1:0] tx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "hold" is the number of edges still to pass before release is
    // allowed (0 = stretch over, waiting for requests to drop); m_run = system out of reset.
    bit            m_run;
    int            m_hold;
    int            m_lk;
    logic [NR+1:0] m_cause;
    int            m_rc;
    int            m_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e, input string tag);
        chk({tag, ".sys_rst_n"}, 32'(sys_rst_n_out), 32'(e.rstn));
        chk({tag, ".state"},     32'(state_out),     32'(e.st));
        chk({tag, ".cause"},     32'(rst_cause_out), 32'(e.cause));
        chk({tag, ".rst_count"}, 32'(reset_count_out), 32'(e.rc));
        chk({tag, ".txev"},      32'(txev_count_out),  32'(e.tx));
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.rstn  = m_run;
        if (m_run)            e.st = 2'd3;
        else if (m_hold == 0) e.st = 2'd2;
        else if (m_hold > SC) e.st = 2'd0;
        else                  e.st = 2'd1;
        e.cause = m_cause;
        e.rc    = 8'(m_rc);
        e.tx    = CW'(m_tx);
        return e;
    endfunction

    task automatic model_por();
        m_run   = 1'b0;
        m_hold  = SS + SC + 1;
        m_lk    = 0;
        m_cause = (NR + 2)'(1);
        m_rc    = 0;
        m_tx    = 0;
    endtask

    task automatic model_edge();
        logic [NR-1:0] av;
        bit            act;
        bit            fire;
        av   = SYSRESETREQ_in & ~rst_req_mask;
        act  = |av;
        fire = 1'b0;
        if (rst_cause_clr) m_cause = '0;
        if (m_run) begin
            if (LOCKUP_in && lockup_rst_en) begin
                m_lk++;
                fire = (LT != 0) && (m_lk == LT);
            end else begin
                m_lk = 0;
            end
            if (act || fire) begin
                m_cause = m_cause | {fire, av, 1'b0};
                m_rc    = (m_rc < 255) ? m_rc + 1 : 255;
                m_tx    = 0;
                m_run   = 1'b0;
                m_hold  = SC;
                m_lk    = 0;
            end else if (TXEV_in) begin
                m_tx = (m_tx < TXMAX) ? m_tx + 1 : TXMAX;
            end
        end else begin
            m_lk = 0;
            if (m_hold > 1)  m_hold--;
            else if (act)    m_hold = 0;
            else             m_run = 1'b1;
        end
    endtask

    task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] mask,
                        input logic lk, input logic en, input logic tx,
                        input logic clr, input logic rn);
        logic was_up;
        @(negedge HCLK);
        was_up         = HRESETn;
        SYSRESETREQ_in = req;
        rst_req_mask   = mask;
        LOCKUP_in      = lk;
        lockup_rst_en  = en;
        TXEV_in        = tx;
        rst_cause_clr  = clr;
        HRESETn        = rn;
        if (!rn) begin
            model_por();
            if (was_up) begin
                #1;
                chk_all(m_expect(), "async_por");
            end
        end else begin
            model_edge();
        end
        q.push_back(m_expect());
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every rising edge the DUT presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all(e, "cyc");
            end
        end
    end

    initial begin
        int lk_burst;
        int req_hold;
        logic [NR-1:0] req_val;
        logic [NR-1:0] mask_val;
        lk_burst = 0;
        req_hold = 0;
        req_val  = '0;
        mask_val = '0;

        #1 HRESETn = 1'b0;
        model_por();
        #1 chk_all(m_expect(), "por_init");

        repeat (2) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(25);

        // Single-cycle request, then a held request that ends in WAIT_REL.
        step(2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        repeat (40) step(2'b10, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        repeat (10) step(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Lockup one short of the timeout, then long enough to fire.
        repeat (31) step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        repeat (34) step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);
        repeat (40) step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // TXEV counting, saturation, and clearing on a request reset.
        repeat (5) step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        repeat (6) step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(2'b01, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(20);

        // Clear coinciding with a trigger, then a clear on its own.
        step(2'b10, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Request and lockup expiry on the same edge.
        repeat (31) step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b01, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);

        // Power-on reset pulsed in the middle of a stretch.
        step(2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        repeat (2) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(25);

        for (int i = 0; i < 2500; i++) begin
            logic lk;
            logic rn;
            if (lk_burst == 0 && $urandom_range(0, 39) == 0)
                lk_burst = $urandom_range(20, 40);
            lk = (lk_burst > 0);
            if (lk_burst > 0) lk_burst--;
            if (req_hold == 0 && $urandom_range(0, 59) == 0) begin
                req_hold = $urandom_range(1, 25);
                req_val  = NR'($urandom);
            end
            if (req_hold > 0) req_hold--;
            else req_val = '0;
            if ($urandom_range(0, 99) == 0) mask_val = NR'($urandom);
            rn = ($urandom_range(0, 599) != 0);
            step(req_val, mask_val, lk, ($urandom_range(0, 7) != 0), 1'($urandom),
                 ($urandom_range(0, 29) == 0), rn);
        end

        repeat (3) @(negedge HCLK);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
